// File: rtl/execute_pipeline_stage.sv
// ---------------------------------------------------------------------------
// execute_pipeline_stage
//
// Execute stage of the 5-stage CPU pipeline, 16-bit datapath. This block holds
// the Decode/Execute (DE) pipeline register, the ALU, the srcB address/data
// split, the result mux and the Execute/Memory (EM) pipeline register.
//
// Flow control: there is no valid/ready handshake. Decode presents a new
// operation on the d_* inputs every cycle and this stage always accepts it;
// Memory always takes the m_* outputs. Nothing stalls.
//
// Timing: d_* sampled at rising edge k -> e_flag* reflect that operation after
// edge k -> m_* reflect it after edge k+1.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   d_wbs                    write-back select
//   d_mm[1:0]                memory-mux select
//   d_aluop[2:0]             ALU operation
//   d_wm                     write-memory enable
//   d_am                     srcB split: 0 = address/data path, 1 = write data
//   d_ni                     next-instruction / branch hint
//   d_wce, d_wme1, d_wme2    write-control / memory-1 / memory-2 enables
//   d_alumux                 result select: 0 = ALU, 1 = srcB address/data
//   d_srcA, d_srcB [W-1:0]   operands
//   e_flagN, e_flagZ         combinational flags of the current ALU result
//   m_*                      registered controls, result, store data, flags
// ---------------------------------------------------------------------------
module execute_pipeline_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d_wbs,
  input  logic [1:0]   d_mm,
  input  logic [2:0]   d_aluop,
  input  logic         d_wm,
  input  logic         d_am,
  input  logic         d_ni,
  input  logic         d_wce,
  input  logic         d_wme1,
  input  logic         d_wme2,
  input  logic         d_alumux,
  input  logic [W-1:0] d_srcA,
  input  logic [W-1:0] d_srcB,
  output logic         e_flagN,
  output logic         e_flagZ,
  output logic         m_wbs,
  output logic [1:0]   m_mm,
  output logic         m_wm,
  output logic         m_ni,
  output logic         m_wce,
  output logic         m_wme1,
  output logic         m_wme2,
  output logic [W-1:0] m_result,
  output logic [W-1:0] m_memdata,
  output logic         m_flagN,
  output logic         m_flagZ
);

  // ALU operation encodings
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_PSB = 3'b111;

  // -------------------------------------------------------------------------
  // DE pipeline register
  // -------------------------------------------------------------------------
  logic         e_wbs;
  logic [1:0]   e_mm;
  logic [2:0]   e_aluop;
  logic         e_wm;
  logic         e_am;
  logic         e_ni;
  logic         e_wce;
  logic         e_wme1;
  logic         e_wme2;
  logic         e_alumux;
  logic [W-1:0] e_srcA;
  logic [W-1:0] e_srcB;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_wbs    <= 1'b0;
      e_mm     <= 2'b00;
      e_aluop  <= 3'b000;
      e_wm     <= 1'b0;
      e_am     <= 1'b0;
      e_ni     <= 1'b0;
      e_wce    <= 1'b0;
      e_wme1   <= 1'b0;
      e_wme2   <= 1'b0;
      e_alumux <= 1'b0;
      e_srcA   <= '0;
      e_srcB   <= '0;
    end else begin
      e_wbs    <= d_wbs;
      e_mm     <= d_mm;
      e_aluop  <= d_aluop;
      e_wm     <= d_wm;
      e_am     <= d_am;
      e_ni     <= d_ni;
      e_wce    <= d_wce;
      e_wme1   <= d_wme1;
      e_wme2   <= d_wme2;
      e_alumux <= d_alumux;
      e_srcA   <= d_srcA;
      e_srcB   <= d_srcB;
    end
  end

  // -------------------------------------------------------------------------
  // ALU: arithmetic wraps mod 2^W; carry and overflow are not kept.
  // Shifts use only the low four bits of srcB as the amount.
  // -------------------------------------------------------------------------
  logic [W-1:0] alu_result;
  logic [3:0]   shamt;

  assign shamt = e_srcB[3:0];

  always_comb begin
    alu_result = '0;
    case (e_aluop)
      OP_ADD:  alu_result = e_srcA + e_srcB;
      OP_SUB:  alu_result = e_srcA - e_srcB;
      OP_AND:  alu_result = e_srcA & e_srcB;
      OP_OR:   alu_result = e_srcA | e_srcB;
      OP_SHL:  alu_result = e_srcA << shamt;
      OP_SHR:  alu_result = e_srcA >> shamt;
      OP_XOR:  alu_result = e_srcA ^ e_srcB;
      OP_PSB:  alu_result = e_srcB;
      default: alu_result = '0;
    endcase
  end

  // Flags always describe the ALU result, even when the mux forwards srcB.
  assign e_flagN = alu_result[W-1];
  assign e_flagZ = (alu_result == '0);

  // -------------------------------------------------------------------------
  // srcB split: srcB goes either to the address/data path or to the store
  // data path; the unused side is held at zero.
  // -------------------------------------------------------------------------
  logic [W-1:0] addr_data;
  logic [W-1:0] wdata;

  always_comb begin
    addr_data = '0;
    wdata     = '0;
    if (e_am) begin
      wdata     = e_srcB;
    end else begin
      addr_data = e_srcB;
    end
  end

  // Result mux
  logic [W-1:0] sel_result;

  assign sel_result = e_alumux ? addr_data : alu_result;

  // -------------------------------------------------------------------------
  // EM pipeline register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      m_wbs     <= 1'b0;
      m_mm      <= 2'b00;
      m_wm      <= 1'b0;
      m_ni      <= 1'b0;
      m_wce     <= 1'b0;
      m_wme1    <= 1'b0;
      m_wme2    <= 1'b0;
      m_result  <= '0;
      m_memdata <= '0;
      m_flagN   <= 1'b0;
      m_flagZ   <= 1'b0;
    end else begin
      m_wbs     <= e_wbs;
      m_mm      <= e_mm;
      m_wm      <= e_wm;
      m_ni      <= e_ni;
      m_wce     <= e_wce;
      m_wme1    <= e_wme1;
      m_wme2    <= e_wme2;
      m_result  <= sel_result;
      m_memdata <= wdata;
      m_flagN   <= e_flagN;
      m_flagZ   <= e_flagZ;
    end
  end

endmodule

// File: tb/tb_execute_pipeline_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_pipeline_stage
//
// Directed plus random stimulus for execute_pipeline_stage. Every driven
// operation has its expected Memory-side outputs pushed to exp_q; the entry is
// popped and compared when that operation reaches the EM register. Flags of
// the operation currently in the DE register are checked each cycle.
// ---------------------------------------------------------------------------
module tb_execute_pipeline_stage;

  localparam int W = 16;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // DUT
  // -------------------------------------------------------------------------
  logic         d_wbs = 1'b0;
  logic [1:0]   d_mm = 2'b00;
  logic [2:0]   d_aluop = 3'b000;
  logic         d_wm = 1'b0;
  logic         d_am = 1'b0;
  logic         d_ni = 1'b0;
  logic         d_wce = 1'b0;
  logic         d_wme1 = 1'b0;
  logic         d_wme2 = 1'b0;
  logic         d_alumux = 1'b0;
  logic [W-1:0] d_srcA = '0;
  logic [W-1:0] d_srcB = '0;
  logic         e_flagN, e_flagZ;
  logic         m_wbs, m_wm, m_ni, m_wce, m_wme1, m_wme2;
  logic [1:0]   m_mm;
  logic [W-1:0] m_result, m_memdata;
  logic         m_flagN, m_flagZ;

  execute_pipeline_stage #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_wbs     (d_wbs),
    .d_mm      (d_mm),
    .d_aluop   (d_aluop),
    .d_wm      (d_wm),
    .d_am      (d_am),
    .d_ni      (d_ni),
    .d_wce     (d_wce),
    .d_wme1    (d_wme1),
    .d_wme2    (d_wme2),
    .d_alumux  (d_alumux),
    .d_srcA    (d_srcA),
    .d_srcB    (d_srcB),
    .e_flagN   (e_flagN),
    .e_flagZ   (e_flagZ),
    .m_wbs     (m_wbs),
    .m_mm      (m_mm),
    .m_wm      (m_wm),
    .m_ni      (m_ni),
    .m_wce     (m_wce),
    .m_wme1    (m_wme1),
    .m_wme2    (m_wme2),
    .m_result  (m_result),
    .m_memdata (m_memdata),
    .m_flagN   (m_flagN),
    .m_flagZ   (m_flagZ)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic         wbs;
    logic [1:0]   mm;
    logic         wm;
    logic         ni;
    logic         wce;
    logic         wme1;
    logic         wme2;
    logic [W-1:0] result;
    logic [W-1:0] memdata;
    logic         flagN;
    logic         flagZ;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model of one operation, written from the operation table.
  // ctrl = {wbs, mm[1:0], wm, ni, wce, wme1, wme2}
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic am,
                                 input logic alumux, input logic [7:0] ctrl);
    exp_t         e;
    logic [W-1:0] alu;
    logic [W-1:0] ad;
    logic [W-1:0] wd;
    case (op)
      3'd0:    alu = a + b;
      3'd1:    alu = a - b;
      3'd2:    alu = a & b;
      3'd3:    alu = a | b;
      3'd4:    alu = a << b[3:0];
      3'd5:    alu = a >> b[3:0];
      3'd6:    alu = a ^ b;
      default: alu = b;
    endcase
    ad        = am ? '0 : b;
    wd        = am ? b : '0;
    e.wbs     = ctrl[7];
    e.mm      = ctrl[6:5];
    e.wm      = ctrl[4];
    e.ni      = ctrl[3];
    e.wce     = ctrl[2];
    e.wme1    = ctrl[1];
    e.wme2    = ctrl[0];
    e.result  = alumux ? ad : alu;
    e.memdata = wd;
    e.flagN   = alu[W-1];
    e.flagZ   = (alu == '0);
    return e;
  endfunction

  task automatic chk_m(input exp_t e);
    chk("m_wbs",     {15'd0, m_wbs},   {15'd0, e.wbs});
    chk("m_mm",      {14'd0, m_mm},    {14'd0, e.mm});
    chk("m_wm",      {15'd0, m_wm},    {15'd0, e.wm});
    chk("m_ni",      {15'd0, m_ni},    {15'd0, e.ni});
    chk("m_wce",     {15'd0, m_wce},   {15'd0, e.wce});
    chk("m_wme1",    {15'd0, m_wme1},  {15'd0, e.wme1});
    chk("m_wme2",    {15'd0, m_wme2},  {15'd0, e.wme2});
    chk("m_result",  m_result,         e.result);
    chk("m_memdata", m_memdata,        e.memdata);
    chk("m_flagN",   {15'd0, m_flagN}, {15'd0, e.flagN});
    chk("m_flagZ",   {15'd0, m_flagZ}, {15'd0, e.flagZ});
  endtask

  // -------------------------------------------------------------------------
  // Driver: apply one operation for one edge, then check the DE-stage flags
  // of this operation and the EM outputs of the operation one edge older.
  // -------------------------------------------------------------------------
  task automatic drive_op(input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic am,
                          input logic alumux, input logic [7:0] ctrl);
    exp_t e;
    d_aluop  = op;
    d_srcA   = a;
    d_srcB   = b;
    d_am     = am;
    d_alumux = alumux;
    {d_wbs, d_mm, d_wm, d_ni, d_wce, d_wme1, d_wme2} = ctrl;
    exp_q.push_back(model(op, a, b, am, alumux, ctrl));
    @(posedge clk);
    #1;
    e = exp_q[exp_q.size()-1];
    chk("e_flagN", {15'd0, e_flagN}, {15'd0, e.flagN});
    chk("e_flagZ", {15'd0, e_flagZ}, {15'd0, e.flagZ});
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      chk_m(e);
    end
  endtask

  // One reset edge with a live operation on the inputs: rst must win.
  task automatic pulse_reset();
    exp_t zero_e;
    rst      = 1'b1;
    d_aluop  = 3'd3;
    d_srcA   = 16'hA5A5;
    d_srcB   = 16'h0F0F;
    d_am     = 1'b1;
    {d_wbs, d_mm, d_wm, d_ni, d_wce, d_wme1, d_wme2} = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    zero_e = '0;
    chk_m(zero_e);
    chk("rst_e_flagN", {15'd0, e_flagN}, 16'd0);
    chk("rst_e_flagZ", {15'd0, e_flagZ}, 16'd1);
    // The cleared DE state (add 0+0) is what reaches EM on the next edge.
    exp_q.delete();
    exp_q.push_back(model(3'd0, '0, '0, 1'b0, 1'b0, 8'h00));
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    // 1: 2-3 -> 0xFFFF, N=1
    drive_op(3'd1, 16'h0002, 16'h0003, 1'b0, 1'b0, 8'h00);
    chk("t1_e_flagN", {15'd0, e_flagN}, 16'd1);
    // 2: 0x50|0x07 with am=1, wm=1
    drive_op(3'd3, 16'h0050, 16'h0007, 1'b1, 1'b0, 8'b0_00_1_0_0_0_0);
    chk("t1_m_result",  m_result,  16'hFFFF);
    chk("t1_m_memdata", m_memdata, 16'h0000);
    chk("t1_m_flagN",   {15'd0, m_flagN}, 16'd1);
    // 3: 1 << 0x1F uses only B[3:0] = 15
    drive_op(3'd4, 16'h0001, 16'h001F, 1'b0, 1'b0, 8'h00);
    chk("t2_m_result",  m_result,  16'h0057);
    chk("t2_m_memdata", m_memdata, 16'h0007);
    chk("t2_m_wm",      {15'd0, m_wm}, 16'd1);
    // 4a: 5-5 -> Z
    drive_op(3'd1, 16'h0005, 16'h0005, 1'b0, 1'b0, 8'h00);
    chk("t3_m_result", m_result, 16'h8000);
    chk("t3_m_flagN",  {15'd0, m_flagN}, 16'd1);
    chk("t3_m_flagZ",  {15'd0, m_flagZ}, 16'd0);
    chk("t4_e_flagZ",  {15'd0, e_flagZ}, 16'd1);
    // 4b: pass B through the address path
    drive_op(3'd7, 16'h0000, 16'h1234, 1'b0, 1'b1, 8'h00);
    // Boundaries: 0x8000-1 and 0-1, logical right shift
    drive_op(3'd1, 16'h8000, 16'h0001, 1'b0, 1'b0, 8'h00);
    chk("t4_m_result", m_result, 16'h1234);
    chk("b1_e_flagN",  {15'd0, e_flagN}, 16'd0);
    drive_op(3'd1, 16'h0000, 16'h0001, 1'b0, 1'b0, 8'h00);
    chk("b1_m_result", m_result, 16'h7FFF);
    chk("b2_e_flagN",  {15'd0, e_flagN}, 16'd1);
    drive_op(3'd5, 16'h8000, 16'h00F4, 1'b0, 1'b0, 8'h00);
    drive_op(3'd6, 16'hFFFF, 16'h00FF, 1'b1, 1'b1, 8'h00);
    chk("b3_m_result", m_result, 16'h0800);
    drive_op(3'd2, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0, 8'h00);
    drive_op(3'd0, 16'hFFFF, 16'h0002, 1'b0, 1'b0, 8'h00);

    // 5: back-to-back with distinct control patterns
    drive_op(3'd0, 16'h1111, 16'h2222, 1'b0, 1'b0, 8'b1_01_0_1_0_1_0);
    drive_op(3'd6, 16'h00FF, 16'h0F0F, 1'b1, 1'b0, 8'b0_10_1_0_1_0_1);
    drive_op(3'd7, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 8'b1_11_0_1_1_1_0);

    // 6: reset mid-stream drops the in-flight op
    drive_op(3'd0, 16'h7777, 16'h1111, 1'b0, 1'b0, 8'hFF);
    pulse_reset();
    drive_op(3'd0, 16'h0003, 16'h0004, 1'b0, 1'b0, 8'b1_10_0_0_0_0_1);
    drive_op(3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00);
    chk("t6_m_result", m_result, 16'h0007);
    chk("t6_m_wbs",    {15'd0, m_wbs}, 16'd1);

    // Random stream
    for (int i = 0; i < 60; i++) begin
      drive_op(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
               16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    // Drain the last queued op
    drive_op(3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
